// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_dd_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;

  // Number of decimal digits needed to represent 2^bin_w - 1.
  function automatic int bcd_digits_for(input int bin_w);
    longint max_val;
    int     ndig;
    max_val = (longint'(1) << bin_w) - 1;
    ndig    = 0;
    for (int i = 0; i < 20; i++) begin
      if (max_val > 0) begin
        ndig    = ndig + 1;
        max_val = max_val / 10;
      end
    end
    if (ndig == 0) ndig = 1;
    return ndig;
  endfunction

endpackage

// File: rtl/bcd_dd_adjust.sv
// Combinational add-3 cell: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_dd_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // Digit values 5..9 map to 8..12, so the 4-bit add never overflows.
  always_comb begin
    adjusted = digit;
    if (digit >= BCD_DIGIT_W'(ADJ_THRESH)) adjusted = digit + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/bcd_dd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per
// enabled clock, with a start/busy/done handshake and a held result register.
module bcd_dd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Reject parameter sets the datapath cannot represent.
  if (BIN_W < 4 || BIN_W > 16) begin : g_bad_width
    $fatal(1, "bcd_dd_seq: BIN_W=%0d outside 4..16", BIN_W);
  end
  if (DIGITS < bcd_digits_for(BIN_W)) begin : g_bad_digits
    $fatal(1, "bcd_dd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  bcd_dd_state_t    state;
  logic [BIN_W-1:0] bin_reg;
  logic [ACC_W-1:0] bcd_acc;
  logic [ACC_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_dd_adjust u_adj (
      .digit   (bcd_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted(bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Controller FSM with shift register, bit counter and registered outputs;
  // ena low freezes everything, including a pending done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      bin_reg <= '0;
      bcd_acc <= '0;
      cnt     <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg <= bin_in;
            bcd_acc <= '0;
            cnt     <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          // The top bit of the adjusted accumulator is always 0 here, so
          // dropping it in the shift loses nothing.
          bcd_acc <= ACC_W'({bcd_adj, bin_reg[BIN_W-1]});
          bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= DONE;
        end
        DONE: begin
          bcd_out <= bcd_acc;
          done    <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_dd_seq.md
Name: bcd_dd_seq

Overview:
Sequential binary-to-BCD converter controller using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It owns the shared shift/adjust datapath and sequences load, iterate and result-publish phases under a start/busy/done handshake. It sits between the binary value source (ui_in path) and the BCD display/output logic inside tt_um_macros77_bcd.

Parameters:
BIN_W, 8, width of the binary input in bits (legal range 4..16)
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_W - 1 (elaboration-time check, fatal on violation)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state (stall), outputs hold
start  input  1  conversion request, sampled only in IDLE with ena=1
bin_in  input  BIN_W  binary operand, captured on the accepted start edge only
busy  output  1  high whenever state != IDLE
done  output  1  single-cycle pulse when the result is published
bcd_out  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; holds last result

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, bcd_out=0, shift register and bit counter cleared. Asserting reset mid-conversion aborts the conversion; no partial result is published.
- States: IDLE, SHIFT, DONE. Every transition below requires ena=1; with ena=0 the state, counter, shift register and outputs hold. A done pulse that coincides with ena=0 is held until ena returns.
- IDLE: when start=1, load bin_reg<=bin_in, bcd_acc<=0, cnt<=0, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each enabled cycle does two things.
  - Per-digit adjust: any bcd_acc digit >= 5 gets +3; digits <= 4 pass unchanged.
  - Shift {bcd_acc, bin_reg} left by 1, then cnt<=cnt+1.
  - When cnt==BIN_W-1 on this cycle, go to DONE.
  - Exactly BIN_W SHIFT cycles per conversion.
- DONE: bcd_out<=bcd_acc, done=1 for this cycle only, then go to IDLE.
- Latency: start accepted at edge 0; done is high during cycle BIN_W+1 (9 cycles for BIN_W=8); bcd_out is valid from that same cycle.
- start while busy=1 is ignored, not queued. bin_in changes after acceptance have no effect.
- Back-to-back operation: start may be accepted in the first IDLE cycle after DONE, giving a throughput of one conversion per BIN_W+2 cycles.
- Width rules:
  - bcd_acc is 4*DIGITS bits; the bit shifted out of the top of bcd_acc is discarded (cannot be 1 given the DIGITS constraint).
  - The adjust add is 4-bit; the result never exceeds 4'hC before the shift.
  - cnt is $clog2(BIN_W) bits wide and never wraps within a conversion.
- busy and done are registered (state-decoded from registered state); no combinational path from any input to any output.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum bcd_dd_state_t {IDLE, SHIFT, DONE}
  - constants BCD_DIGIT_W=4 and ADJ_THRESH=5
  - function bcd_digits_for(bin_w), used for the DIGITS legality check
- Sub-module bcd_dd_adjust: purely combinational 4-bit digit cell (in>=5 ? in+3 : in), generate-instantiated DIGITS times.
- The controller FSM, counter and shift register stay in bcd_dd_seq.

Test Plan:
- Reset release, bin_in=8'd255, pulse start -> busy=1 from the next cycle; done pulse 9 cycles after start; bcd_out=12'h255; busy=0 the following cycle.
- bin_in=0 and bin_in=99 -> bcd_out=12'h000 and 12'h099 respectively, each with the same 9-cycle latency.
- Exhaustive 0..255 with back-to-back starts issued the cycle after each done -> every bcd_out matches the decimal reference; one done per start; conversions spaced 10 cycles apart.
- Start accepted with bin_in=200; re-pulse start with bin_in=17 at cycle 3 -> second start ignored; result 12'h200; exactly one done.
- bin_in=128; drop ena for 4 cycles mid-SHIFT -> state frozen; done arrives at cycle 13 instead of 9; bcd_out=12'h128.
- bin_in=255; assert rst_n=0 asynchronously at cycle 5 -> busy, done and bcd_out go to 0 immediately with no done pulse; after release, a new start with bin_in=42 -> 12'h042.
